// File: rtl/alu_step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_step_sequencer                                         |
// | Description : Moore control sequencer that walks a single ALU            |
// |               instruction through its datapath micro-steps.              |
// |               An instruction is latched on an accepted start. The block  |
// |               then emits bus-drive, register-load and ALU strobes, one   |
// |               state per clock.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   Clock     in   1   rising-edge clock                                   |
// |   clear     in   1   asynchronous active-low reset                       |
// |   start     in   1   execute request, sampled only in IDLE               |
// |   ir        in  32   instruction {opcode[31:27],Ra,Rb,Rc,unused[14:0]}   |
// |   op        out  5   ALU opcode, valid only while Zhighin/Zlowin high    |
// |   Rout      out 16   one-hot register-to-bus drive enables               |
// |   Rin       out 16   one-hot bus-to-register load enables                |
// |   Yin..LOin out  1   datapath strobes                                    |
// |   busy      out  1   high whenever the sequencer is outside IDLE         |
// |   done      out  1   one-cycle completion pulse                          |
// |   err       out  1   one-cycle illegal-opcode pulse                      |
// +--------------------------------------------------------------------------+
module alu_step_sequencer (
   input  logic        Clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] ir,
   output logic [4:0]  op,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        Yin,
   output logic        Zhighin,
   output logic        Zlowin,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIin,
   output logic        LOin,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T_Y  = 3'd1;
   localparam logic [2:0] S_T_OP = 3'd2;
   localparam logic [2:0] S_T_LO = 3'd3;
   localparam logic [2:0] S_T_HI = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;
   localparam logic [2:0] S_BAD  = 3'd6;

   localparam logic [1:0] CLS_TWO    = 2'd0;
   localparam logic [1:0] CLS_WIDE   = 2'd1;
   localparam logic [1:0] CLS_SINGLE = 2'd2;
   localparam logic [1:0] CLS_ILLEGAL = 2'd3;

   localparam logic [4:0] OPC_MUL = 5'b01111;
   localparam logic [4:0] OPC_DIV = 5'b10000;
   localparam logic [4:0] OPC_NEG = 5'b10001;
   localparam logic [4:0] OPC_NOT = 5'b10010;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [4:0] opc_lat;
   logic [3:0] ra_lat;
   logic [3:0] rb_lat;
   logic [3:0] rc_lat;
   logic [1:0] cls_in;
   logic [1:0] cls_lat;

   // The low 15 instruction bits carry no meaning for this sequencer.
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[14:0];

   function automatic logic [1:0] classify(input logic [4:0] opc);
      logic [1:0] cls;
      if (opc == OPC_MUL || opc == OPC_DIV)
         cls = CLS_WIDE;
      else if (opc == OPC_NEG || opc == OPC_NOT)
         cls = CLS_SINGLE;
      else if (opc < OPC_MUL)
         cls = CLS_TWO;
      else
         cls = CLS_ILLEGAL;
      return cls;
   endfunction

   // IDLE routing must look at the live opcode because the latch is
   // loaded on the same edge that leaves IDLE.
   assign cls_in  = classify(ir[31:27]);
   assign cls_lat = classify(opc_lat);

   // State register and instruction latch
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state   <= S_IDLE;
         opc_lat <= 5'd0;
         ra_lat  <= 4'd0;
         rb_lat  <= 4'd0;
         rc_lat  <= 4'd0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start) begin
            opc_lat <= ir[31:27];
            ra_lat  <= ir[26:23];
            rb_lat  <= ir[22:19];
            rc_lat  <= ir[18:15];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE: begin
            if (!start)
               state_nxt = S_IDLE;
            else if (cls_in == CLS_ILLEGAL)
               state_nxt = S_BAD;
            else if (cls_in == CLS_SINGLE)
               state_nxt = S_T_OP;
            else
               state_nxt = S_T_Y;
         end
         S_T_Y:  state_nxt = S_T_OP;
         S_T_OP: state_nxt = S_T_LO;
         S_T_LO: state_nxt = (cls_lat == CLS_WIDE) ? S_T_HI : S_FIN;
         S_T_HI: state_nxt = S_FIN;
         S_FIN:  state_nxt = S_IDLE;
         S_BAD:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore output decode: only state and latched fields are used, so the
   // bus drivers stay glitch-free with respect to the start/ir inputs.
   always_comb begin
      op       = 5'd0;
      Rout     = 16'd0;
      Rin      = 16'd0;
      Yin      = 1'b0;
      Zhighin  = 1'b0;
      Zlowin   = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      err      = 1'b0;
      case (state)
         S_IDLE: busy = 1'b0;
         S_T_Y: begin
            Rout = 16'd1 << rb_lat;
            Yin  = 1'b1;
         end
         S_T_OP: begin
            // Single-operand ops take their only source from the Rb field.
            Rout    = (cls_lat == CLS_SINGLE) ? (16'd1 << rb_lat)
                                              : (16'd1 << rc_lat);
            op      = opc_lat;
            Zhighin = 1'b1;
            Zlowin  = 1'b1;
         end
         S_T_LO: begin
            Zlowout = 1'b1;
            // Wide results go to LO/HI instead of the register file.
            if (cls_lat == CLS_WIDE)
               LOin = 1'b1;
            else
               Rin  = 16'd1 << ra_lat;
         end
         S_T_HI: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         S_FIN: done = 1'b1;
         S_BAD: err  = 1'b1;
         default: busy = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_step_sequencer                                      |
// | Description : Self-checking bench for alu_step_sequencer. Expected       |
// |               per-cycle output vectors come from an instruction-level    |
// |               model that lists the micro-steps of each opcode class.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_step_sequencer;

   typedef logic [46:0] vec_t;

   logic        Clock;
   logic        clear;
   logic        start;
   logic [31:0] ir;
   logic [4:0]  op;
   logic [15:0] Rout;
   logic [15:0] Rin;
   logic        Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin;
   logic        busy, done, err;

   int total = 0;
   int bad   = 0;
   vec_t exp_q[$];

   alu_step_sequencer dut (
      .Clock    (Clock),
      .clear    (clear),
      .start    (start),
      .ir       (ir),
      .op       (op),
      .Rout     (Rout),
      .Rin      (Rin),
      .Yin      (Yin),
      .Zhighin  (Zhighin),
      .Zlowin   (Zlowin),
      .Zhighout (Zhighout),
      .Zlowout  (Zlowout),
      .HIin     (HIin),
      .LOin     (LOin),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Vector layout: op, Rout, Rin, Yin, Zhighin, Zlowin, Zhighout, Zlowout,
   // HIin, LOin, busy, done, err.
   function automatic vec_t pack(input logic [4:0] f_op, input logic [15:0] f_rout,
                                 input logic [15:0] f_rin, input logic [6:0] strobes,
                                 input logic f_busy, input logic f_done, input logic f_err);
      return {f_op, f_rout, f_rin, strobes, f_busy, f_done, f_err};
   endfunction

   function automatic logic [31:0] mk_ir(input int opc, input int ra, input int rb, input int rc);
      logic [31:0] w;
      w = '0;
      w[31:27] = opc[4:0];
      w[26:23] = ra[3:0];
      w[22:19] = rb[3:0];
      w[18:15] = rc[3:0];
      w[14:0]  = 15'($urandom);
      return w;
   endfunction

   // Instruction-level model: the list of cycles an instruction occupies
   // after acceptance, each with the outputs that cycle must show.
   // Strobe order: {Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin}.
   task automatic build_expected(input logic [31:0] w);
      int opc, ra, rb, rc;
      bit legal, wide, single;
      opc = int'(w[31:27]);
      ra  = int'(w[26:23]);
      rb  = int'(w[22:19]);
      rc  = int'(w[18:15]);
      wide   = (opc == 15) || (opc == 16);
      single = (opc == 17) || (opc == 18);
      legal  = (opc <= 18);
      exp_q.delete();
      if (!legal) begin
         exp_q.push_back(pack(5'd0, 16'd0, 16'd0, 7'b0000000, 1'b1, 1'b0, 1'b1));
      end else begin
         if (!single)
            exp_q.push_back(pack(5'd0, 16'(1 << rb), 16'd0, 7'b1000000, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(pack(5'(opc), 16'(1 << (single ? rb : rc)), 16'd0,
                              7'b0110000, 1'b1, 1'b0, 1'b0));
         if (wide) begin
            exp_q.push_back(pack(5'd0, 16'd0, 16'd0, 7'b0000101, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(pack(5'd0, 16'd0, 16'd0, 7'b0001010, 1'b1, 1'b0, 1'b0));
         end else begin
            exp_q.push_back(pack(5'd0, 16'd0, 16'(1 << ra), 7'b0000100, 1'b1, 1'b0, 1'b0));
         end
         exp_q.push_back(pack(5'd0, 16'd0, 16'd0, 7'b0000000, 1'b1, 1'b1, 1'b0));
      end
   endtask

   task automatic check_now(input string tag, input vec_t expv);
      vec_t obs;
      int drivers;
      obs = pack(op, Rout, Rin, {Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin},
                 busy, done, err);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
      // At most one register and one bus source may drive at once.
      drivers = (Rout != 16'd0 ? 1 : 0) + int'(Zhighout) + int'(Zlowout);
      total++;
      assert (($countones(Rout) <= 1) && (drivers <= 1)) else begin
         bad++;
         $error("FAIL %s_bus observed Rout=%h Zh=%b Zl=%b expected single driver",
                tag, Rout, Zhighout, Zlowout);
      end
   endtask

   function automatic vec_t idle_vec();
      return pack(5'd0, 16'd0, 16'd0, 7'b0000000, 1'b0, 1'b0, 1'b0);
   endfunction

   // Entered 1 time unit after a rising edge with the sequencer in IDLE.
   // Returns in the IDLE cycle that follows completion, after checking it.
   task automatic run_seq(input string name, input logic [31:0] w, input bit hold);
      ir    = w;
      start = 1'b1;
      build_expected(w);
      @(posedge Clock); #1;
      if (!hold) start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         ir = $urandom;
         check_now($sformatf("%s_c%0d", name, i + 1), exp_q[i]);
         @(posedge Clock); #1;
      end
      check_now($sformatf("%s_idle", name), idle_vec());
   endtask

   task automatic idle_cycles(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         ir = $urandom;
         @(posedge Clock); #1;
         check_now("idle", idle_vec());
      end
   endtask

   // Accept an instruction, advance k cycles into it, then assert clear mid-cycle.
   task automatic abort_after(input string name, input logic [31:0] w, input int k);
      ir    = w;
      start = 1'b1;
      build_expected(w);
      @(posedge Clock); #1;
      start = 1'b0;
      for (int i = 0; i < k; i++) begin
         check_now($sformatf("%s_pre%0d", name, i + 1), exp_q[i]);
         @(posedge Clock); #1;
      end
      check_now($sformatf("%s_pre%0d", name, k + 1), exp_q[k]);
      #2 clear = 1'b0;
      #1 check_now($sformatf("%s_async", name), idle_vec());
      @(posedge Clock); #1;
      check_now($sformatf("%s_held", name), idle_vec());
      clear = 1'b1;
   endtask

   initial begin
      clear = 1'b0;
      start = 1'b0;
      ir    = 32'hFFFF_FFFF;
      #1 check_now("reset_async", idle_vec());
      @(posedge Clock); #1;
      start = 1'b1;
      check_now("reset_held", idle_vec());
      start = 1'b0;
      clear = 1'b1;
      idle_cycles(2);

      // Directed examples
      run_seq("add_ex", 32'h1A8C_0000, 1'b0);
      idle_cycles(1);
      run_seq("mul_ex", mk_ir(15, 9, 2, 3), 1'b0);
      run_seq("not_ex", mk_ir(18, 4, 7, 11), 1'b0);
      run_seq("ill_ex", mk_ir(31, 1, 2, 3), 1'b0);
      run_seq("div_ex", mk_ir(16, 0, 15, 15), 1'b0);
      run_seq("neg_same", mk_ir(17, 6, 6, 6), 1'b0);
      run_seq("two_max", mk_ir(14, 15, 15, 0), 1'b0);
      run_seq("ill_19", mk_ir(19, 3, 3, 3), 1'b0);

      // Start held across back-to-back instructions
      run_seq("hold_a", mk_ir(3, 5, 1, 8), 1'b1);
      run_seq("hold_b", mk_ir(15, 2, 4, 6), 1'b1);
      run_seq("hold_c", mk_ir(18, 12, 13, 0), 1'b0);

      // Abort in T_OP, then idle with no pulses
      abort_after("abort1", mk_ir(3, 5, 1, 8), 1);
      idle_cycles(3);
      // Abort in wide T_HI, then start on the first edge after release
      abort_after("abort2", mk_ir(16, 1, 2, 3), 3);
      run_seq("post_abort", mk_ir(7, 10, 11, 12), 1'b0);

      // Randomised instructions with random gaps and random holding
      for (int n = 0; n < 60; n++) begin
         bit hold;
         hold = ($urandom_range(0, 3) == 0);
         run_seq($sformatf("rnd%0d", n),
                 mk_ir($urandom_range(0, 31), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15)), hold);
         if (!hold && $urandom_range(0, 1) == 1)
            idle_cycles($urandom_range(1, 2));
      end
      start = 1'b0;
      idle_cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_step_sequencer.md
ALU_STEP_SEQUENCER -- requirements
Module: alu_step_sequencer

Interface
REQ-001 Clock  input  1  single clock; all state changes on rising edge.
REQ-002 clear  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request to execute the instruction in ir; sampled only in IDLE.
REQ-004 ir  input  32  instruction word: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-005 op  output  5  ALU operation code to the datapath, valid while Zhighin/Zlowin are asserted, else 0.
REQ-006 Rout  output  16  one-hot register-to-bus enables (bit n = Rn); all-zero when no register drives.
REQ-007 Rin  output  16  one-hot bus-to-register load enables (bit n = Rn).
REQ-008 Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin  output  1 each  datapath strobes.
REQ-009 busy  output  1  high from the cycle after start is accepted until return to IDLE.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 err  output  1  one-cycle pulse on illegal opcode.

Function
REQ-012 States: IDLE, T_Y, T_OP, T_LO, T_HI, FIN, BAD; one state per clock cycle; all outputs decoded from state and latched instruction only (Moore).
REQ-013 In IDLE with start=1, ir is latched and next state is chosen by opcode; start=0 keeps IDLE; ir changes after latch have no effect.
REQ-014 Opcode classes: two-operand 00000-01110; wide 01111 (mul), 10000 (div); single-operand 10001 (neg), 10010 (not); all others illegal.
REQ-015 Two-operand and wide: IDLE -> T_Y; single-operand: IDLE -> T_OP; illegal: IDLE -> BAD.
REQ-016 T_Y: Rout one-hot of Rb, Yin=1; next T_OP.
REQ-017 T_OP: Rout one-hot of Rc (Rb for single-operand), op=opcode, Zhighin=Zlowin=1; next T_LO.
REQ-018 T_LO: Zlowout=1; Rin one-hot of Ra for non-wide, LOin=1 instead for wide; next T_HI if wide, else FIN.
REQ-019 T_HI: Zhighout=1, HIin=1; next FIN.
REQ-020 FIN: done=1, no strobes; next IDLE.
REQ-021 BAD: err=1, no strobes, Rout=Rin=0; next IDLE.
REQ-022 Latency start-accept edge to done pulse: 4 cycles two-operand, 3 single-operand, 5 wide; illegal: err in first cycle after accept.
REQ-023 At most one bit of Rout and at most one bus driver (Rout, Zhighout, Zlowout) active in any cycle.
REQ-024 start asserted while busy is ignored; no queuing; a start in the FIN cycle is ignored, next accept possible in following IDLE cycle.
REQ-025 Register index 0-15 maps directly to bit position; Ra=Rb=Rc allowed, no special handling.
REQ-026 busy=1 in T_Y, T_OP, T_LO, T_HI, FIN, BAD; 0 in IDLE.

Reset
REQ-027 clear=0 forces IDLE immediately, independent of Clock; all outputs 0, latched instruction 0.
REQ-028 clear asserted mid-sequence aborts with no done/err pulse and no further strobes; release resumes from IDLE requiring a new start.
REQ-029 start sampled in the first rising edge after clear deasserts is accepted normally.

Verification
REQ-030 ir=0x1A8C0000 (op 00011, Ra=5, Rb=1, Rc=8), start 1 cycle -> T_Y Rout=0x0002 Yin; T_OP Rout=0x0100 op=3 Zhigh/lowin; T_LO Zlowout Rin=0x0020; done 4 cycles after accept.
REQ-031 mul opcode 01111, Rb=2, Rc=3 -> T_LO Zlowout+LOin Rin=0; T_HI Zhighout+HIin; done at 5 cycles; Rin never set.
REQ-032 not opcode 10010, Ra=4, Rb=7 -> no Yin; T_OP Rout=0x0080 op=0x12; T_LO Rin=0x0010; done at 3 cycles.
REQ-033 opcode 11111 -> err pulse one cycle, no strobes, busy one cycle, IDLE after.
REQ-034 clear low during T_OP of two-operand op -> all outputs 0 asynchronously, no done; new start after release completes normally.
REQ-035 start held high continuously across two instructions -> second accepted only in the IDLE cycle after FIN; inputs changed mid-sequence ignored.
